// File: rtl/rv_ctrl_pkg.sv
// rv_ctrl_pkg: shared state/class enums, opcode constants and output encodings for the multicycle control path
package rv_ctrl_pkg;
  typedef enum logic [2:0] {
    S_FETCH, S_WAIT_I, S_DECODE, S_EXEC, S_MEM, S_WAIT_D, S_WB, S_TRAP
  } state_t;
  typedef enum logic [3:0] {
    C_ALU_R, C_ALU_I, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_LOAD, C_STORE
  } iclass_t;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [1:0] PC_PLUS4  = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] WB_ALU    = 2'b00;
  localparam logic [1:0] WB_LOAD   = 2'b01;
  localparam logic [1:0] WB_LINK   = 2'b10;
  localparam logic [1:0] TC_ILLEGAL  = 2'b00;
  localparam logic [1:0] TC_MISALIGN = 2'b01;
  localparam logic [1:0] TC_TIMEOUT  = 2'b10;
endpackage

// File: rtl/ctrl_decode_class.sv
// ctrl_decode_class: combinational opcode to instruction class with illegal-opcode flag
module ctrl_decode_class
  import rv_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output iclass_t    cls,
  output logic       illegal
);
  always_comb begin
    cls = C_ALU_R;
    illegal = 1'b0;
    case (opcode)
      OP_OP:     cls = C_ALU_R;
      OP_IMM:    cls = C_ALU_I;
      OP_LUI:    cls = C_LUI;
      OP_AUIPC:  cls = C_AUIPC;
      OP_JAL:    cls = C_JAL;
      OP_JALR:   cls = C_JALR;
      OP_BRANCH: cls = C_BRANCH;
      OP_LOAD:   cls = C_LOAD;
      OP_STORE:  cls = C_STORE;
      default:   illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes, traps and perf counters
module multicycle_ctrl
  import rv_ctrl_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int CNT_WIDTH      = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 branch_taken,
  input  logic [2:0]           addr_lo,
  input  logic                 halt_req,
  output logic                 imem_req,
  input  logic                 imem_ready,
  input  logic                 imem_rvalid,
  output logic                 dmem_req,
  output logic                 dmem_we,
  input  logic                 dmem_ready,
  input  logic                 dmem_rvalid,
  output logic                 ir_we,
  output logic                 pc_we,
  output logic [1:0]           pc_src,
  output logic                 alu_b_sel,
  output logic                 alu_a_sel,
  output logic                 rf_we,
  output logic [1:0]           wb_sel,
  output logic                 retire,
  output logic                 halted,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  state_t state, state_n;
  iclass_t cls_q, dec_cls;
  logic dec_illegal, wait_st, tmo_hit, misaligned;
  logic [1:0] cause_q, cause_n;
  logic [TW-1:0] tmo_cnt;
  logic [2:0] amask;
  // the signed/unsigned bit of funct3 does not change the access size
  logic unused_f3;
  assign unused_f3 = funct3[2];
  ctrl_decode_class u_dec (.opcode(opcode), .cls(dec_cls), .illegal(dec_illegal));
  assign amask = funct3[1:0] == 2'b00 ? 3'b000 :
                 funct3[1:0] == 2'b01 ? 3'b001 :
                 funct3[1:0] == 2'b10 ? 3'b011 : (XLEN == 64 ? 3'b111 : 3'b011);
  assign misaligned = |(addr_lo & amask);
  assign wait_st = (state == S_FETCH && !halt_req) || state == S_WAIT_I || state == S_MEM || state == S_WAIT_D;
  assign tmo_hit = TIMEOUT_CYCLES != 0 && wait_st && tmo_cnt == TMO_LAST;
  always_comb begin
    state_n = state;
    cause_n = cause_q;
    {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_b_sel, alu_a_sel} = '0;
    {rf_we, wb_sel, retire, halted, trap, trap_cause} = '0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          halted = halt_req;
          imem_req = !halt_req;
          if (!halt_req && imem_ready) state_n = S_WAIT_I;
        end
        S_WAIT_I: begin
          ir_we = imem_rvalid;
          if (imem_rvalid) state_n = S_DECODE;
        end
        S_DECODE: begin
          state_n = dec_illegal ? S_TRAP : S_EXEC;
          cause_n = dec_illegal ? TC_ILLEGAL : cause_q;
        end
        S_EXEC: begin
          if (cls_q == C_BRANCH) begin
            pc_we = 1'b1;
            pc_src = branch_taken ? PC_BRANCH : PC_PLUS4;
            retire = 1'b1;
            state_n = S_FETCH;
          end else if (cls_q == C_LOAD || cls_q == C_STORE) begin
            state_n = misaligned ? S_TRAP : S_MEM;
            cause_n = misaligned ? TC_MISALIGN : cause_q;
          end else begin
            state_n = S_WB;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we = cls_q == C_STORE;
          pc_we = dmem_ready && dmem_we;
          retire = dmem_ready && dmem_we;
          if (dmem_ready) state_n = dmem_we ? S_FETCH : S_WAIT_D;
        end
        S_WAIT_D: begin
          wb_sel = WB_LOAD;
          if (dmem_rvalid) state_n = S_WB;
        end
        S_WB: begin
          rf_we = 1'b1;
          pc_we = 1'b1;
          retire = 1'b1;
          pc_src = (cls_q == C_JAL || cls_q == C_JALR) ? PC_JUMP : PC_PLUS4;
          wb_sel = (cls_q == C_JAL || cls_q == C_JALR) ? WB_LINK : cls_q == C_LOAD ? WB_LOAD : WB_ALU;
          state_n = S_FETCH;
        end
        default: begin
          trap = 1'b1;
          trap_cause = cause_q;
        end
      endcase
      if (state inside {S_EXEC, S_MEM, S_WAIT_D, S_WB}) begin
        alu_b_sel = !(cls_q inside {C_ALU_R, C_BRANCH});
        alu_a_sel = cls_q inside {C_AUIPC, C_JAL};
      end
      // a handshake landing in the timeout cycle has already moved state_n on
      if (tmo_hit && state_n == state) begin
        state_n = S_TRAP;
        cause_n = TC_TIMEOUT;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
      cls_q <= C_ALU_R;
      cause_q <= TC_ILLEGAL;
      tmo_cnt <= '0;
      cycle_cnt <= '0;
      instret_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == S_DECODE) cls_q <= dec_cls;
      cause_q <= cause_n;
      tmo_cnt <= (wait_st && state_n == state) ? tmo_cnt + TW'(1) : '0;
      cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      instret_cnt <= instret_cnt + CNT_WIDTH'(retire);
    end
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed vectors for multicycle_ctrl with hand-computed cycle counts and selects
module tb_multicycle_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0, addr_lo = '0;
  logic branch_taken = 1'b0, halt_req = 1'b0;
  logic imem_req, imem_ready = 1'b1, imem_rvalid = 1'b1;
  logic dmem_req, dmem_we, dmem_ready = 1'b1, dmem_rvalid = 1'b1;
  logic ir_we, pc_we, alu_b_sel, alu_a_sel, rf_we, retire, halted, trap;
  logic [1:0] pc_src, wb_sel, trap_cause;
  logic [63:0] cycle_cnt, instret_cnt;
  logic [16:0] outs;
  int n_chk = 0, n_pass = 0, halt_cyc = 0;
  int r_cyc, r_rf, r_pcwe, r_trap;
  logic [1:0] r_pcsrc, r_wbsel, r_cause;
  logic r_dreq, r_dwe, r_bsel;
  logic [63:0] cc0;
  always #5 clk = ~clk;
  multicycle_ctrl #(.XLEN(64), .CNT_WIDTH(64), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .branch_taken(branch_taken),
    .addr_lo(addr_lo), .halt_req(halt_req), .imem_req(imem_req), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dmem_rvalid(dmem_rvalid), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_b_sel(alu_b_sel), .alu_a_sel(alu_a_sel), .rf_we(rf_we), .wb_sel(wb_sel),
    .retire(retire), .halted(halted), .trap(trap), .trap_cause(trap_cause),
    .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
  );
  assign outs = {imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_src, alu_b_sel, alu_a_sel,
                 rf_we, wb_sel, retire, halted, trap, trap_cause};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask
  // starts at the beginning of a FETCH cycle; ends at the start of the cycle after retire or trap
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic tk, input logic [2:0] alo);
    opcode = op; funct3 = f3; branch_taken = tk; addr_lo = alo;
    r_cyc = 0; r_rf = 0; r_pcwe = 0; r_trap = 0; r_pcsrc = 0; r_wbsel = 0; r_cause = 0;
    r_dreq = 0; r_dwe = 0; r_bsel = 0;
    for (int n = 1; n <= 20; n++) begin
      if (n == halt_cyc) halt_req = 1'b1;
      @(negedge clk);
      if (rf_we) begin r_rf++; r_wbsel = wb_sel; r_bsel = alu_b_sel; end
      if (pc_we) begin r_pcwe = n; r_pcsrc = pc_src; end
      if (dmem_req) begin r_dreq = 1'b1; r_dwe = dmem_we; end
      if (trap) begin r_trap = n; r_cause = trap_cause; break; end
      if (retire) begin r_cyc = n; break; end
      next_cycle();
    end
    next_cycle();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask
  initial begin
    @(negedge clk);
    chk("rst_outs_first", outs, 0);
    next_cycle();
    @(negedge clk);
    chk("rst_outs", outs, 0);
    chk("rst_cycle_cnt", cycle_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    next_cycle();
    rst = 1'b0;
    run_instr(7'b0010011, 3'b000, 1'b0, 3'b000);
    chk("addi_cycles", r_cyc, 5);
    chk("addi_rf_we_count", r_rf, 1);
    chk("addi_wb_sel", r_wbsel, 2'b00);
    chk("addi_alu_b_imm", r_bsel, 1);
    chk("addi_instret", instret_cnt, 1);
    chk("addi_cycle_cnt", cycle_cnt, 5);
    run_instr(7'b1100011, 3'b000, 1'b1, 3'b000);
    chk("beq_t_cycles", r_cyc, 4);
    chk("beq_t_pc_we_cyc", r_pcwe, 4);
    chk("beq_t_pc_src", r_pcsrc, 2'b01);
    chk("beq_t_rf_we", r_rf, 0);
    run_instr(7'b1100011, 3'b000, 1'b0, 3'b000);
    chk("beq_nt_cycles", r_cyc, 4);
    chk("beq_nt_pc_src", r_pcsrc, 2'b00);
    chk("beq_nt_rf_we", r_rf, 0);
    run_instr(7'b1101111, 3'b000, 1'b0, 3'b000);
    chk("jal_cycles", r_cyc, 5);
    chk("jal_wb_sel", r_wbsel, 2'b10);
    chk("jal_pc_src", r_pcsrc, 2'b10);
    run_instr(7'b0100011, 3'b011, 1'b0, 3'b000);
    chk("sd_cycles", r_cyc, 5);
    chk("sd_dmem_we", r_dwe, 1);
    chk("sd_rf_we", r_rf, 0);
    run_instr(7'b0000011, 3'b010, 1'b0, 3'b100);
    chk("lw_cycles", r_cyc, 7);
    chk("lw_wb_sel", r_wbsel, 2'b01);
    chk("lw_dmem_req", r_dreq, 1);
    chk("instret_six", instret_cnt, 6);
    run_instr(7'b0000011, 3'b011, 1'b0, 3'b100);
    chk("ld_mis_trap_cyc", r_trap, 5);
    chk("ld_mis_cause", r_cause, 2'b01);
    chk("ld_mis_no_dreq", r_dreq, 0);
    do_reset();
    run_instr(7'b0010011, 3'b000, 1'b0, 3'b000);
    run_instr(7'b1111111, 3'b000, 1'b0, 3'b000);
    chk("illegal_trap_cyc", r_trap, 4);
    chk("illegal_cause", r_cause, 2'b00);
    cc0 = cycle_cnt;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("trap_cycle_cnt", cycle_cnt, cc0 + 5);
    chk("trap_instret_frozen", instret_cnt, 1);
    chk("trap_sticky", {trap, trap_cause, imem_req}, 4'b1000);
    do_reset();
    imem_ready = 1'b0;
    r_rf = 0;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      if (imem_req) r_rf++;
      next_cycle();
    end
    chk("imem_req_stable", r_rf, 3);
    imem_ready = 1'b1;
    run_instr(7'b0010011, 3'b000, 1'b0, 3'b000);
    chk("ready_wins_timeout", {r_trap, r_cyc}, {32'd0, 32'd5});
    imem_ready = 1'b0;
    r_trap = 0;
    r_cause = 0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (trap) begin r_trap = n; r_cause = trap_cause; break; end
      next_cycle();
    end
    chk("timeout_trap_cyc", r_trap, 5);
    chk("timeout_cause", r_cause, 2'b10);
    imem_ready = 1'b1;
    do_reset();
    halt_cyc = 5;
    run_instr(7'b0000011, 3'b011, 1'b0, 3'b000);
    halt_cyc = 0;
    chk("halt_ld_cycles", r_cyc, 7);
    @(negedge clk);
    chk("halted_after_ld", {halted, imem_req}, 2'b10);
    next_cycle();
    @(negedge clk);
    chk("halted_held", {halted, imem_req}, 2'b10);
    next_cycle();
    halt_req = 1'b0;
    run_instr(7'b0010011, 3'b000, 1'b0, 3'b000);
    chk("resume_cycles", r_cyc, 5);
    opcode = 7'b0000011; funct3 = 3'b011; addr_lo = 3'b000;
    dmem_rvalid = 1'b0;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("wait_d_wb_sel", {wb_sel, dmem_req}, 3'b010);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cycle_outs", outs, 0);
    next_cycle();
    @(negedge clk);
    chk("post_rst_outs", outs, 0);
    chk("post_rst_counters", {cycle_cnt, instret_cnt}, 0);
    next_cycle();
    rst = 1'b0;
    dmem_rvalid = 1'b1;
    run_instr(7'b0010011, 3'b000, 1'b0, 3'b000);
    chk("recover_cycles", r_cyc, 5);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
